// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: sequences cache status/read/write commands and RAM write-back/refill for one CPU access at a time
`timescale 1ns/1ps
module dm_cache_ctrl #(
  parameter int ramWidth      = 8,
  parameter int addrWidth     = 8,
  parameter int blockAddrBits = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cpuReq,
  input  logic                 cpuWe,
  input  logic [addrWidth-1:0] cpuAddr,
  input  logic [ramWidth-1:0]  cpuDataIn,
  output logic [ramWidth-1:0]  cpuDataOut,
  output logic                 cpuReady,
  output logic                 busy,
  output logic [1:0]           cntrl,
  output logic [addrWidth-1:0] cacheAddr,
  output logic [ramWidth-1:0]  cacheDataIn,
  input  logic [ramWidth-1:0]  cacheDataOut,
  input  logic                 isHit,
  input  logic                 isClean,
  input  logic [ramWidth-1:0]  dataOutRAM,
  input  logic [addrWidth-1:0] addrOutRAM,
  output logic                 ramReq,
  output logic                 ramWe,
  output logic [addrWidth-1:0] ramAddr,
  output logic [ramWidth-1:0]  ramDataOut,
  input  logic [ramWidth-1:0]  ramDataIn,
  input  logic                 ramAck
);
  typedef enum logic [3:0] {CLEAR, IDLE, CHECK, READ, WRITE, WBACK, FILL, REFILL, DONE} state_t;
  state_t st, nxt;
  logic [addrWidth-1:0] addr_q, vaddr_q;
  logic [ramWidth-1:0]  data_q, vdata_q;
  logic                 we_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= CLEAR;
    else st <= nxt;
  always_comb begin
    nxt = st;
    case (st)
      CLEAR:   nxt = IDLE;
      IDLE:    nxt = cpuReq ? CHECK : IDLE;
      CHECK:   nxt = isHit ? (we_q ? WRITE : READ) : isClean ? (we_q ? WRITE : FILL) : WBACK;
      READ:    nxt = DONE;
      WRITE:   nxt = DONE;
      WBACK:   nxt = ramAck ? (we_q ? WRITE : FILL) : WBACK;
      FILL:    nxt = ramAck ? REFILL : FILL;
      REFILL:  nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = CLEAR;
    endcase
  end
  // victim address/data are frozen at the end of CHECK so the write-back stays stable while RAM stalls
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr_q     <= '0;
      we_q       <= 1'b0;
      data_q     <= '0;
      vaddr_q    <= '0;
      vdata_q    <= '0;
      cpuDataOut <= '0;
    end else begin
      if (st == IDLE && cpuReq) begin
        addr_q <= {cpuAddr[addrWidth-1:blockAddrBits], cpuAddr[blockAddrBits-1:0]};
        we_q   <= cpuWe;
        data_q <= cpuDataIn;
      end
      if (st == CHECK) begin
        vaddr_q <= addrOutRAM;
        vdata_q <= dataOutRAM;
      end
      if (st == READ) cpuDataOut <= cacheDataOut;
      if (st == FILL && ramAck) cpuDataOut <= ramDataIn;
    end
  always_comb begin
    cntrl       = (st == CLEAR) ? 2'b00 : (st == READ) ? 2'b10 : (st == WRITE || st == REFILL) ? 2'b11 : 2'b01;
    cacheAddr   = (st == CLEAR) ? '0 : (st == IDLE) ? cpuAddr : addr_q;
    cacheDataIn = (st == WRITE) ? data_q : (st == REFILL) ? cpuDataOut : '0;
    ramReq      = (st == WBACK) || (st == FILL);
    ramWe       = (st == WBACK);
    ramAddr     = (st == WBACK) ? vaddr_q : (st == FILL) ? addr_q : '0;
    ramDataOut  = (st == WBACK) ? vdata_q : '0;
    cpuReady    = (st == DONE);
    busy        = (st != IDLE);
  end
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb_dm_cache_ctrl: directed bench with a behavioural negedge cache array and a RAM responder with programmable wait
`timescale 1ns/1ps
module tb_dm_cache_ctrl;
  logic clk = 0, rst_n = 0, cpuReq = 0, cpuWe = 0;
  logic [7:0] cpuAddr = 0, cpuDataIn = 0;
  logic [7:0] cpuDataOut, cacheAddr, cacheDataIn, ramAddr, ramDataOut;
  logic [1:0] cntrl;
  logic cpuReady, busy, ramReq, ramWe;
  logic [7:0] cacheDataOut = 0, dataOutRAM = 0, addrOutRAM = 0, ramDataIn = 0;
  logic isHit = 0, isClean = 0, ramAck = 0;
  int checks = 0, errors = 0;
  int ram_wait = 0;
  logic ram_hold = 0;
  int wb_cnt = 0, fetch_cnt = 0;
  logic [7:0] wb_addr = 0, wb_data = 0, fetch_addr = 0;

  dm_cache_ctrl #(.ramWidth(8), .addrWidth(8), .blockAddrBits(4)) dut (
    .clk(clk), .rst_n(rst_n), .cpuReq(cpuReq), .cpuWe(cpuWe), .cpuAddr(cpuAddr),
    .cpuDataIn(cpuDataIn), .cpuDataOut(cpuDataOut), .cpuReady(cpuReady), .busy(busy),
    .cntrl(cntrl), .cacheAddr(cacheAddr), .cacheDataIn(cacheDataIn), .cacheDataOut(cacheDataOut),
    .isHit(isHit), .isClean(isClean), .dataOutRAM(dataOutRAM), .addrOutRAM(addrOutRAM),
    .ramReq(ramReq), .ramWe(ramWe), .ramAddr(ramAddr), .ramDataOut(ramDataOut),
    .ramDataIn(ramDataIn), .ramAck(ramAck));

  always #5 clk = ~clk;

  logic [3:0] ctag [16];
  logic [7:0] cdata [16];
  logic       cdirty [16];
  initial begin
    for (int i = 0; i < 16; i++) begin ctag[i] = 0; cdata[i] = 0; cdirty[i] = 0; end
    forever begin
      @(negedge clk);
      case (cntrl)
        2'b00: for (int i = 0; i < 16; i++) begin ctag[i] = 0; cdata[i] = 0; cdirty[i] = 0; end
        2'b01: begin
          isHit = (ctag[cacheAddr[3:0]] == cacheAddr[7:4]);
          isClean = !cdirty[cacheAddr[3:0]];
          dataOutRAM = cdata[cacheAddr[3:0]];
          addrOutRAM = {ctag[cacheAddr[3:0]], cacheAddr[3:0]};
        end
        2'b10: cacheDataOut = cdata[cacheAddr[3:0]];
        default: begin
          ctag[cacheAddr[3:0]] = cacheAddr[7:4];
          cdata[cacheAddr[3:0]] = cacheDataIn;
          cdirty[cacheAddr[3:0]] = 1;
        end
      endcase
    end
  end

  logic [7:0] ram [256];
  initial begin
    int rcnt;
    rcnt = 0;
    for (int i = 0; i < 256; i++) ram[i] = 0;
    ram[8'h45] = 8'h3C;
    ram[8'h27] = 8'h5E;
    forever begin
      @(negedge clk);
      ramAck = 0;
      if (!ramReq || ram_hold) rcnt = 0;
      else if (rcnt < ram_wait) rcnt++;
      else begin
        ramAck = 1;
        rcnt = 0;
        if (ramWe) begin ram[ramAddr] = ramDataOut; wb_addr = ramAddr; wb_data = ramDataOut; wb_cnt++; end
        else begin ramDataIn = ram[ramAddr]; fetch_addr = ramAddr; fetch_cnt++; end
      end
    end
  end

  task automatic access(input logic we, input logic [7:0] a, input logic [7:0] d, output int lat,
                        output logic [7:0] dout, output logic saw_wr, output logic [7:0] wr_data, output logic saw_req);
    @(negedge clk);
    checks++; if (busy !== 0 || cpuReady !== 0) begin errors++; $display("FAIL idle_before addr=%h busy=%b ready=%b required 0 0", a, busy, cpuReady); end
    cpuReq = 1; cpuWe = we; cpuAddr = a; cpuDataIn = d;
    lat = 0; saw_wr = 0; wr_data = 0; saw_req = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin cpuReq = 0; cpuWe = ~we; cpuAddr = 8'hFF; cpuDataIn = 8'hFF; end
      if (ramReq) saw_req = 1;
      if (cntrl == 2'b11) begin saw_wr = 1; wr_data = cacheDataIn; end
    end while (!cpuReady && lat < 40);
    dout = cpuDataOut;
    checks++; if (cpuReady !== 1) begin errors++; $display("FAIL ready_timeout addr=%h ready=%b required 1", a, cpuReady); end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (cntrl !== 2'b00 || busy !== 1 || cpuReady !== 0 || ramReq !== 0 || ramWe !== 0) begin errors++; $display("FAIL reset_ctrl cntrl=%b busy=%b rdy=%b req=%b we=%b required 00 1 0 0 0", cntrl, busy, cpuReady, ramReq, ramWe); end
    checks++; if (cpuDataOut !== 0 || cacheAddr !== 0 || cacheDataIn !== 0 || ramAddr !== 0 || ramDataOut !== 0) begin errors++; $display("FAIL reset_data dout=%h ca=%h cdi=%h ra=%h rdo=%h required all 0", cpuDataOut, cacheAddr, cacheDataIn, ramAddr, ramDataOut); end
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    checks++; if (cntrl !== 2'b00 || busy !== 1 || ramReq !== 0) begin errors++; $display("FAIL clear_cycle cntrl=%b busy=%b req=%b required 00 1 0", cntrl, busy, ramReq); end
    @(negedge clk);
    cpuAddr = 8'h5A; #1;
    checks++; if (cntrl !== 2'b01 || busy !== 0 || ramReq !== 0) begin errors++; $display("FAIL idle_cycle cntrl=%b busy=%b req=%b required 01 0 0", cntrl, busy, ramReq); end
    checks++; if (cacheAddr !== 8'h5A) begin errors++; $display("FAIL idle_addr cacheAddr=%h required 5a", cacheAddr); end
  endtask

  task automatic test_store_clean_miss();
    int lat; logic [7:0] dout, wd; logic sw, sr;
    access(1, 8'h35, 8'hA5, lat, dout, sw, wd, sr);
    checks++; if (lat !== 3) begin errors++; $display("FAIL st_miss_lat lat=%0d required 3", lat); end
    checks++; if (sw !== 1 || wd !== 8'hA5) begin errors++; $display("FAIL st_miss_write saw=%b data=%h required 1 a5", sw, wd); end
    checks++; if (sr !== 0) begin errors++; $display("FAIL st_miss_noram req=%b required 0", sr); end
  endtask

  task automatic test_load_hit(input logic [7:0] a, input logic [7:0] exp);
    int lat; logic [7:0] dout, wd; logic sw, sr;
    access(0, a, 8'h00, lat, dout, sw, wd, sr);
    checks++; if (lat !== 3) begin errors++; $display("FAIL hit_lat addr=%h lat=%0d required 3", a, lat); end
    checks++; if (dout !== exp) begin errors++; $display("FAIL hit_data addr=%h data=%h required %h", a, dout, exp); end
    checks++; if (sr !== 0 || sw !== 0) begin errors++; $display("FAIL hit_quiet addr=%h req=%b wr=%b required 0 0", a, sr, sw); end
  endtask

  task automatic test_dirty_miss_load();
    int lat, w0, f0; logic [7:0] dout, wd; logic sw, sr;
    ram_wait = 2; w0 = wb_cnt; f0 = fetch_cnt;
    access(0, 8'h45, 8'h00, lat, dout, sw, wd, sr);
    checks++; if (lat !== 9) begin errors++; $display("FAIL dm_lat lat=%0d required 9", lat); end
    checks++; if (wb_cnt !== w0 + 1 || wb_addr !== 8'h35 || wb_data !== 8'hA5) begin errors++; $display("FAIL dm_wback n=%0d addr=%h data=%h required %0d 35 a5", wb_cnt - w0, wb_addr, wb_data, 1); end
    checks++; if (fetch_cnt !== f0 + 1 || fetch_addr !== 8'h45) begin errors++; $display("FAIL dm_fetch n=%0d addr=%h required 1 45", fetch_cnt - f0, fetch_addr); end
    checks++; if (dout !== 8'h3C || sw !== 1 || wd !== 8'h3C) begin errors++; $display("FAIL dm_data dout=%h refill=%b/%h required 3c 1/3c", dout, sw, wd); end
    @(negedge clk);
    checks++; if (cpuReady !== 0 || busy !== 0) begin errors++; $display("FAIL dm_ready_once rdy=%b busy=%b required 0 0", cpuReady, busy); end
    ram_wait = 0;
  endtask

  task automatic test_clean_miss_load();
    int lat, w0; logic [7:0] dout, wd; logic sw, sr;
    w0 = wb_cnt;
    access(0, 8'h27, 8'h00, lat, dout, sw, wd, sr);
    checks++; if (lat !== 4) begin errors++; $display("FAIL cm_lat lat=%0d required 4", lat); end
    checks++; if (dout !== 8'h5E || wd !== 8'h5E || fetch_addr !== 8'h27 || wb_cnt !== w0) begin errors++; $display("FAIL cm_data dout=%h refill=%h faddr=%h wbs=%0d required 5e 5e 27 0", dout, wd, fetch_addr, wb_cnt - w0); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [7:0] dout, wd; logic sw, sr;
    access(1, 8'h12, 8'h77, lat, dout, sw, wd, sr);
    checks++; if (lat !== 3 || wd !== 8'h77) begin errors++; $display("FAIL b2b_store lat=%0d data=%h required 3 77", lat, wd); end
    access(0, 8'h12, 8'h00, lat, dout, sw, wd, sr);
    checks++; if (lat !== 3 || dout !== 8'h77) begin errors++; $display("FAIL b2b_load lat=%0d data=%h required 3 77", lat, dout); end
  endtask

  task automatic test_dirty_miss_store();
    int lat, f0; logic [7:0] dout, wd; logic sw, sr;
    f0 = fetch_cnt;
    access(1, 8'h65, 8'h11, lat, dout, sw, wd, sr);
    checks++; if (lat !== 4) begin errors++; $display("FAIL ds_lat lat=%0d required 4", lat); end
    checks++; if (wb_addr !== 8'h45 || wb_data !== 8'h3C || wd !== 8'h11 || fetch_cnt !== f0) begin errors++; $display("FAIL ds_data wb=%h/%h wr=%h fetches=%0d required 45/3c 11 0", wb_addr, wb_data, wd, fetch_cnt - f0); end
  endtask

  task automatic test_reset_wback();
    int n, w0, lat; logic [7:0] dout, wd; logic sw, sr;
    ram_hold = 1; w0 = wb_cnt;
    @(negedge clk);
    cpuReq = 1; cpuWe = 0; cpuAddr = 8'h35;
    n = 0;
    do begin @(negedge clk); n++; cpuReq = 0; end while (!ramReq && n < 20);
    checks++; if (ramReq !== 1 || ramWe !== 1 || ramAddr !== 8'h65 || ramDataOut !== 8'h11) begin errors++; $display("FAIL rw_wback req=%b we=%b addr=%h data=%h required 1 1 65 11", ramReq, ramWe, ramAddr, ramDataOut); end
    repeat (2) @(negedge clk);
    checks++; if (ramReq !== 1 || ramAddr !== 8'h65) begin errors++; $display("FAIL rw_hold req=%b addr=%h required 1 65", ramReq, ramAddr); end
    rst_n = 0; #1;
    checks++; if (ramReq !== 0 || cntrl !== 2'b00 || busy !== 1 || cpuReady !== 0) begin errors++; $display("FAIL rw_async req=%b cntrl=%b busy=%b rdy=%b required 0 00 1 0", ramReq, cntrl, busy, cpuReady); end
    ram_hold = 0;
    @(negedge clk);
    checks++; if (wb_cnt !== w0) begin errors++; $display("FAIL rw_abandon wbs=%0d required 0", wb_cnt - w0); end
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    access(0, 8'h35, 8'h00, lat, dout, sw, wd, sr);
    checks++; if (lat !== 4 || fetch_addr !== 8'h35 || dout !== 8'hA5 || wb_cnt !== w0) begin errors++; $display("FAIL rw_refetch lat=%0d faddr=%h data=%h wbs=%0d required 4 35 a5 0", lat, fetch_addr, dout, wb_cnt - w0); end
  endtask

  initial begin
    test_reset();
    test_store_clean_miss();
    test_load_hit(8'h35, 8'hA5);
    test_dirty_miss_load();
    test_load_hit(8'h45, 8'h3C);
    test_clean_miss_load();
    test_back_to_back();
    test_dirty_miss_store();
    test_reset_wback();
    test_load_hit(8'h03, 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout time=%0t required finish earlier", $time);
    $fatal(1);
  end
endmodule
